// File: rtl/instruction_fetch.sv
// Instruction fetch: one outstanding memory request feeding a two-entry {pc, instruction} buffer.
// Optional macro FETCH_MISALIGN_TRAP_EN adds a sticky trap on misaligned redirects that halts fetch.
module instruction_fetch #(
    parameter logic [63:0] RESET_PC = 64'h0
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    output logic [63:0] imem_req_addr,
    input  logic        imem_req_ready,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    input  logic        redirect_valid,
    input  logic [63:0] redirect_target,
    output logic        if_valid,
    input  logic        if_ready,
    output logic [31:0] if_instruction,
`ifdef FETCH_MISALIGN_TRAP_EN
    output logic        fetch_misaligned,
    output logic [63:0] fetch_misaligned_pc,
`endif
    output logic [63:0] if_pc
);
    typedef enum logic [1:0] {S_REQ = 2'd0, S_WAIT = 2'd1, S_KILL = 2'd2} state_t;

    state_t      state_q, state_d;
    logic [63:0] fetch_pc_q, fetch_pc_d;
    logic [63:0] pending_pc_q, pending_pc_d;
    logic [1:0]  cnt_q, cnt_d;
    logic [63:0] buf_pc_q  [2];
    logic [63:0] buf_pc_d  [2];
    logic [31:0] buf_ins_q [2];
    logic [31:0] buf_ins_d [2];
    logic        req_block;
    logic        accept;
    logic        push;
    logic        pop;
    logic [1:0]  cnt_popped;

`ifdef FETCH_MISALIGN_TRAP_EN
    logic        mis_q, mis_d;
    logic [63:0] mis_pc_q, mis_pc_d;
    assign req_block           = mis_q;
    assign fetch_misaligned    = mis_q;
    assign fetch_misaligned_pc = mis_pc_q;
`else
    assign req_block = 1'b0;
`endif

    // Requests are gated on the registered count only, so a same-cycle pop never unlocks a request.
    assign imem_req_valid = (state_q == S_REQ) && (cnt_q < 2'd2) && !redirect_valid && !rst && !req_block;
    assign imem_req_addr  = fetch_pc_q;
    assign if_valid       = (cnt_q != 2'd0);
    assign if_pc          = if_valid ? buf_pc_q[0] : 64'd0;
    assign if_instruction = if_valid ? buf_ins_q[0] : 32'd0;

    assign accept     = imem_req_valid && imem_req_ready;
    assign push       = (state_q == S_WAIT) && imem_resp_valid && !redirect_valid;
    assign pop        = if_valid && if_ready;
    assign cnt_popped = cnt_q - {1'b0, pop};

    always_comb begin
        state_d      = state_q;
        fetch_pc_d   = fetch_pc_q;
        pending_pc_d = pending_pc_q;
        cnt_d        = cnt_popped + {1'b0, push};
        buf_pc_d     = buf_pc_q;
        buf_ins_d    = buf_ins_q;
`ifdef FETCH_MISALIGN_TRAP_EN
        mis_d        = mis_q;
        mis_pc_d     = mis_pc_q;
`endif
        case (state_q)
            S_REQ: begin
                if (accept) begin
                    pending_pc_d = fetch_pc_q;
                    fetch_pc_d   = fetch_pc_q + 64'd4;
                    state_d      = S_WAIT;
                end
            end
            S_WAIT: begin
                if (imem_resp_valid) begin
                    state_d = S_REQ;
                end else if (redirect_valid) begin
                    state_d = S_KILL;
                end
            end
            S_KILL: begin
                if (imem_resp_valid) begin
                    state_d = S_REQ;
                end
            end
            default: state_d = S_REQ;
        endcase

        if (pop) begin
            buf_pc_d[0]  = buf_pc_q[1];
            buf_ins_d[0] = buf_ins_q[1];
        end
        if (push) begin
            buf_pc_d[cnt_popped[0]]  = pending_pc_q;
            buf_ins_d[cnt_popped[0]] = imem_resp_data;
        end

        // A redirect wins over any same-cycle push or pop and empties the buffer.
        if (redirect_valid) begin
            cnt_d      = 2'd0;
            fetch_pc_d = {redirect_target[63:2], 2'b00};
`ifdef FETCH_MISALIGN_TRAP_EN
            mis_d = (redirect_target[1:0] != 2'b00);
            if (redirect_target[1:0] != 2'b00) begin
                mis_pc_d = redirect_target;
            end
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_REQ;
            fetch_pc_q   <= RESET_PC;
            pending_pc_q <= 64'd0;
            cnt_q        <= 2'd0;
`ifdef FETCH_MISALIGN_TRAP_EN
            mis_q        <= 1'b0;
            mis_pc_q     <= 64'd0;
`endif
        end else begin
            state_q      <= state_d;
            fetch_pc_q   <= fetch_pc_d;
            pending_pc_q <= pending_pc_d;
            cnt_q        <= cnt_d;
`ifdef FETCH_MISALIGN_TRAP_EN
            mis_q        <= mis_d;
            mis_pc_q     <= mis_pc_d;
`endif
        end
    end

    // Buffer payload needs no reset: outputs are masked to zero while the count is zero.
    always_ff @(posedge clk) begin
        buf_pc_q  <= buf_pc_d;
        buf_ins_q <= buf_ins_d;
    end
endmodule
